// File: rtl/mul_seq_if.sv
// Start/end-of-conversion handshake bundle for mul_seq: operands and soc in, eoc and product out.
interface mul_seq_if #(
   parameter int N = 8
);
   logic           soc;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           eoc;
   logic [2*N-1:0] p;

   modport master (output soc, output a, output b, input eoc, input p);
   modport slave  (input soc, input a, input b, output eoc, output p);
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier, N clocks per product, soc/eoc handshake.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands and product.
module mul_seq #(
   parameter int N = 8
) (
   input  logic      clock,
   input  logic      reset,
   mul_seq_if.slave  bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

   state_t          state_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    pHi_q;
   logic [N-1:0]    pLo_q;
   logic [CW-1:0]   cnt_q;
   logic            eoc_q;

   logic            lastStep;
   logic [N-1:0]    addY;
   logic [N-1:0]    addS;
   logic [N-1:0]    stepSum;
   logic            shiftIn;
   logic [N-1:0]    pHi_d;
   logic [N-1:0]    pLo_d;

   assign lastStep = (cnt_q == CW'(N - 1));
   assign addY     = pLo_q[0] ? a_q : '0;

`ifdef MUL_SEQ_SIGNED_EN
   logic [N-1:0]    diffD;
   logic            addOw;
   logic            diffOw;

   // The multiplier MSB carries weight -2^(N-1), so the final partial product is subtracted.
   always_comb begin
      addS    = pHi_q + addY;
      diffD   = pHi_q - a_q;
      addOw   = (pHi_q[N-1] == addY[N-1]) && (addS[N-1] != pHi_q[N-1]);
      diffOw  = (pHi_q[N-1] != a_q[N-1]) && (diffD[N-1] != pHi_q[N-1]);
      stepSum = addS;
      shiftIn = addS[N-1] ^ addOw;
      if (lastStep && pLo_q[0]) begin
         stepSum = diffD;
         shiftIn = diffD[N-1] ^ diffOw;
      end
   end
`else
   logic            addC;

   always_comb begin
      {addC, addS} = {1'b0, pHi_q} + {1'b0, addY};
      stepSum      = addS;
      shiftIn      = addC;
   end
`endif

   assign pHi_d = {shiftIn, stepSum[N-1:1]};
   assign pLo_d = {stepSum[0], pLo_q[N-1:1]};

   // DONE holds until soc drops so a level-held soc cannot retrigger a second product.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         eoc_q   <= 1'b1;
         a_q     <= '0;
         pHi_q   <= '0;
         pLo_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               eoc_q <= 1'b1;
               if (bus.soc) begin
                  a_q     <= bus.a;
                  pHi_q   <= '0;
                  pLo_q   <= bus.b;
                  cnt_q   <= '0;
                  eoc_q   <= 1'b0;
                  state_q <= STEP;
               end
            end
            STEP: begin
               pHi_q <= pHi_d;
               pLo_q <= pLo_d;
               cnt_q <= cnt_q + CW'(1);
               if (lastStep) begin
                  eoc_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               eoc_q <= 1'b1;
               if (!bus.soc) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               eoc_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.eoc = eoc_q;
   assign bus.p   = {pHi_q, pLo_q};
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential shift-and-add multiplier for base-2 naturals, N-bit operands and a 2N-bit product.
- Owns a single N-bit add unit (x, y, c_in -> s, c_out, ow) and steps it once per clock for N clocks.
- Talks to the outside world with the soc/eoc start/end handshake used by the team's other sequential units.
- Lets the datapath multiply without an N×N combinational array.

Parameters:
- N, 8, operand width in bits; must be >= 2. The product is 2N bits wide.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and the reset values below.
- soc  input  1  start of conversion; level-sensitive, sampled only in IDLE and DONE.
- a  input  N  multiplicand; captured on the accepting edge.
- b  input  N  multiplier; captured on the accepting edge.
- eoc  output  1  end of conversion; 1 = idle, or product valid.
- p  output  2N  product {P_hi, P_lo}; meaningful only while eoc=1.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, eoc=1, p=0, step counter=0, A=0.
- Internal registers:
  - A (N bits), the captured multiplicand.
  - P_hi (N bits) and P_lo (N bits); P_lo holds the not-yet-consumed multiplier bits.
  - CNT, ceil(log2 N) bits.
- State IDLE:
  - eoc=1.
  - If soc=1 at an edge: A<=a, P_hi<=0, P_lo<=b, CNT<=0, go to STEP.
- State STEP: eoc=0; one multiplier bit per edge.
  - Adder wiring: x=P_hi, y=(P_lo[0] ? A : 0), c_in=0.
  - Update: {P_hi, P_lo} <= {c_out, s, P_lo[N-1:1]}, i.e. an (N+1)-bit sum shifted right by one.
  - CNT increments. When CNT==N-1 at the edge, go to DONE instead of staying in STEP.
- State DONE:
  - eoc=1; p holds the final product.
  - Stay while soc=1. When soc=0, go to IDLE with p unchanged.
  - This state prevents a held-high soc from restarting the operation.
- Latency: the acceptance edge is edge 0. eoc falls after edge 0 and rises after edge N, with p valid at that point. Exactly N busy cycles.
- Width rule: the product of two N-bit naturals always fits in 2N bits, so there is no overflow output.
- a/b changes after acceptance have no effect. soc is ignored during STEP.
- Reset mid-operation: immediate abort to IDLE, eoc=1, p=0. The next soc starts a clean operation.
- p during STEP is the partial shift register; its value is don't-care and the bench must not check it.

Optional Feature:
- Macro: MUL_SEQ_SIGNED_EN.
- Defined: a, b and p are two's complement. Each STEP differs from the unsigned case as follows:
  - Shift-in bit is the true sign of the (N+1)-bit result, (s[N-1] ^ ow), instead of c_out.
  - When P_lo[0]=0, the shift-in bit is P_hi[N-1] (arithmetic shift).
  - In the last step (CNT==N-1) with P_lo[0]=1, the controller uses a diff unit (x=P_hi, y=A, b_in=0), since the multiplier MSB has weight -2^(N-1).
  - The shift-in bit in that step is (d[N-1] ^ ow).
- Not defined: unsigned behaviour only; no diff unit is instantiated.
- Latency and handshake are identical in both builds.

Test Plan:
- N=8, a=13, b=11, soc pulse -> eoc=0 for 8 cycles, then eoc=1, p=16'h008F.
- a=255, b=255 -> p=16'hFE01. Then a=0, b=200 -> p=16'h0000.
- Hold soc=1 for 20 cycles after acceptance -> single operation only; eoc stays 1 in DONE; p stable; IDLE re-entered only after soc=0.
- Change a/b during STEP (a=13, b=11 captured, then a=b=255) -> p=16'h008F.
- Assert reset after the 3rd STEP edge -> eoc=1 and p=0 asynchronously. A new soc with a=2, b=3 -> p=16'h0006 after 8 cycles.
- With MUL_SEQ_SIGNED_EN:
  - a=-3 (8'hFD), b=5 -> p=16'hFFF1.
  - a=-128, b=-128 -> p=16'h4000.
  - a=127, b=-1 -> p=16'hFF81.
